// File: rtl/synchro_serializer.sv
// synchro_serializer: plays a latched WORD-bit bus value out one bit at a time,
// as a one-cycle zeroes/ones pulse plus a timed led blink (short = 0, long = 1).
// Build option: define SERIALIZER_LSB_FIRST_EN to emit bit 0 first instead of
// the MSB; timing is identical in both builds.
module synchro_serializer #(
    parameter int WORD = 4,
    parameter int UNIT = 25_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD-1:0] bus,
    output logic            zeroes,
    output logic            ones,
    output logic            led,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(3 * UNIT);
    localparam int IW = (WORD > 1) ? $clog2(WORD) : 1;

    // Phase counters hold (length - 1) and end the phase when they reach 0.
    localparam logic [CW-1:0] T_SHORT = CW'(UNIT - 1);
    localparam logic [CW-1:0] T_LONG  = CW'(3 * UNIT - 1);
    localparam logic [CW-1:0] T_OFF   = CW'(2 * UNIT - 1);

`ifdef SERIALIZER_LSB_FIRST_EN
    localparam logic [IW-1:0] IDX_FIRST = IW'(0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WORD - 1);
`else
    localparam logic [IW-1:0] IDX_FIRST = IW'(WORD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(0);
`endif

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idx, idx_n;
    logic [WORD-1:0] shadow, shadow_n;

    logic zeroes_n, ones_n, led_n, busy_n, done_n;
    logic pulse, bit_n;

    // State, phase counter, bit index and shadow word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shadow <= shadow_n;
        end
    end

    // Next-state logic: latch the word on start, time ON/OFF phases, step the index.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shadow_n = shadow;
        case (state)
            S_IDLE: begin
                if (start) begin
                    shadow_n = bus;
                    idx_n    = IDX_FIRST;
                    state_n  = S_ON;
                    cnt_n    = bus[IDX_FIRST] ? T_LONG : T_SHORT;
                end
            end
            S_ON: begin
                if (cnt == '0) begin
                    state_n = S_OFF;
                    cnt_n   = T_OFF;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_OFF: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (idx == IDX_LAST) begin
                    state_n = S_IDLE;
                end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
                    idx_n = idx + IW'(1);
`else
                    idx_n = idx - IW'(1);
`endif
                    state_n = S_ON;
                    cnt_n   = shadow[idx_n] ? T_LONG : T_SHORT;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        pulse    = (state_n == S_ON) && (state != S_ON);
        bit_n    = shadow_n[idx_n];
        led_n    = (state_n == S_ON);
        busy_n   = (state_n != S_IDLE);
        ones_n   = pulse && bit_n;
        zeroes_n = pulse && !bit_n;
        done_n   = (state == S_OFF) && (state_n == S_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zeroes <= 1'b0;
            ones   <= 1'b0;
            led    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            zeroes <= zeroes_n;
            ones   <= ones_n;
            led    <= led_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_synchro_serializer.sv
// Scoreboard bench for synchro_serializer (WORD=4, UNIT=4). The driver builds the
// expected per-cycle output trace of each accepted frame from the bit timing rules
// and queues it; a monitor pops one entry per cycle and compares.
module tb_synchro_serializer;

    localparam int WORD = 4;
    localparam int UNIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [WORD-1:0] bus;
    logic            zeroes, ones, led, busy, done;

    // expected vector layout: {busy, led, ones, zeroes, done}
    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    synchro_serializer #(.WORD(WORD), .UNIT(UNIT)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .zeroes(zeroes), .ones(ones), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected trace of one frame, built directly from the bit timing rules.
    task automatic push_frame(input logic [WORD-1:0] w);
        for (int k = 0; k < WORD; k++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            logic b = w[k];
`else
            logic b = w[WORD-1-k];
`endif
            int on_len = b ? 3 * UNIT : UNIT;
            for (int c = 0; c < on_len; c++)
                exp_q.push_back({1'b1, 1'b1, (c == 0) && b, (c == 0) && !b, 1'b0});
            for (int c = 0; c < 2 * UNIT; c++)
                exp_q.push_back(5'b10000);
        end
        exp_q.push_back(5'b00001);
    endtask

    // One stimulus cycle; a start is taken only when the model has no frame in flight.
    task automatic drive(input logic s, input logic [WORD-1:0] b);
        @(negedge clk);
        start = s;
        bus   = b;
        if (s && !reset && exp_q.size() == 0) push_frame(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, WORD'($urandom));
    endtask

    // Monitor: compare every cycle against the queued trace (empty queue = idle outputs).
    initial begin
        logic [4:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
            act_v = {busy, led, ones, zeroes, done};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL trace cycle %0d: got busy/led/ones/zeroes/done=%b expected %b",
                         cyc_no, act_v, exp_v);
            end
            if (ones && zeroes) begin
                errors++;
                $display("FAIL exclusive cycle %0d: ones and zeroes both high", cyc_no);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle after reset: busy must stay low
        idle(40);

        // directed words, including back-to-back via start held through done
        drive(1'b1, 4'b1010); idle(70);
        drive(1'b1, 4'b0000); idle(55);
        drive(1'b1, 4'b1111); idle(85);
        drive(1'b1, 4'b0001); idle(60);
        for (int i = 0; i < 150; i++) drive(1'b1, 4'b0110);
        idle(80);

        // reset at N+20 of a 1010 frame: outputs clear at once, no done
        drive(1'b1, 4'b1010);
        idle(19);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({busy, led, ones, zeroes, done} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000", {busy, led, ones, zeroes, done});
        end
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        drive(1'b1, 4'b1010); idle(70);

        // random start pulses and bus churn, including mid-frame
        for (int i = 0; i < 3000; i++) drive(($urandom_range(0, 9) == 0), WORD'($urandom));
        idle(100);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
